// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo.
// The master modport is the client side; the slave modport is the FIFO itself.
interface sync_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
);
    logic                 w_en;
    logic [DATA_BITS-1:0] w_data;
    logic                 r_en;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_BITS:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output w_en, w_data, r_en,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, w_data, r_en,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port, occupancy counter,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// Full/empty are derived from the occupancy count, never from pointer compare.
module sync_fifo #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4,
    parameter int AF_LVL    = 14,
    parameter int AE_LVL    = 2
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AF_CNT    = (ADDR_BITS + 1)'(AF_LVL);
    localparam logic [ADDR_BITS:0] AE_CNT    = (ADDR_BITS + 1)'(AE_LVL);

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [ADDR_BITS:0]   wp;
    logic [ADDR_BITS:0]   rp;
    logic [ADDR_BITS:0]   count_q;
    logic [ADDR_BITS:0]   count_nxt;
    logic [DATA_BITS-1:0] r_data_q;
    logic                 r_valid_q;
    logic                 full_q;
    logic                 empty_q;
    logic                 af_q;
    logic                 ae_q;
    logic                 ov_q;
    logic                 un_q;
    logic                 wa;
    logic                 ra;

    // Accept decisions and next occupancy; a read on a full FIFO frees the slot
    // the same edge, so the write is accepted too. No write-to-read bypass.
    always_comb begin
        ra        = bus.r_en && !empty_q;
        wa        = bus.w_en && (!full_q || ra);
        count_nxt = count_q;
        case ({wa, ra})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    // Storage array: not reset, and reset blocks any write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && wa) begin
            mem[wp[ADDR_BITS-1:0]] <= bus.w_data;
        end
    end

    // Pointers, count, read port, and flags registered from next-state count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count_q   <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ov_q      <= 1'b0;
            un_q      <= 1'b0;
        end else begin
            if (wa) begin
                wp <= wp + 1'b1;
            end
            if (ra) begin
                rp       <= rp + 1'b1;
                r_data_q <= mem[rp[ADDR_BITS-1:0]];
            end
            r_valid_q <= ra;
            count_q   <= count_nxt;
            full_q    <= (count_nxt == DEPTH_CNT);
            empty_q   <= (count_nxt == '0);
            af_q      <= (count_nxt >= AF_CNT);
            ae_q      <= (count_nxt <= AE_CNT);
            if (bus.w_en && !wa) begin
                ov_q <= 1'b1;
            end
            if (bus.r_en && empty_q) begin
                un_q <= 1'b1;
            end
        end
    end

    assign bus.r_data       = r_data_q;
    assign bus.r_valid      = r_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ov_q;
    assign bus.underflow    = un_q;
endmodule
